// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline register (MAIN + SKID) with valid/ready handshake,
// redirect bubble injection, flush, and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 EXC_W     = 5,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h20080000,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_opc,
    input  logic [EXC_W-1:0]   in_exccode,
    input  logic               flush,
    input  logic               redirect,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_opc,
    output logic [EXC_W-1:0]   out_exccode,
    output logic               out_is_nop,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [PC_W-1:0]    main_pc, skid_pc;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic [PC_W-1:0]    main_opc, skid_opc;
    logic [EXC_W-1:0]   main_exccode, skid_exccode;
    logic               main_is_nop;

    logic accept, drain;
    logic main_from_in, main_from_skid, skid_from_in;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // Readiness depends only on registered state, never on out_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else if (redirect) begin
            next_state = ONE;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    next_state   = ONE;
                    main_from_in = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        main_from_in = 1'b1;
                    end else if (accept) begin
                        next_state   = FULL;
                        skid_from_in = 1'b1;
                    end else if (drain) begin
                        next_state = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    next_state     = ONE;
                    main_from_skid = 1'b1;
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // Payload is cleared by reset as well, so outputs read zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            main_pc      <= '0;
            main_instr   <= '0;
            main_opc     <= '0;
            main_exccode <= '0;
            main_is_nop  <= 1'b0;
            skid_pc      <= '0;
            skid_instr   <= '0;
            skid_opc     <= '0;
            skid_exccode <= '0;
        end else if (redirect) begin
            main_pc      <= in_pc;
            main_instr   <= NOP_INSTR;
            main_opc     <= '0;
            main_exccode <= '0;
            main_is_nop  <= 1'b1;
            skid_pc      <= '0;
            skid_instr   <= '0;
            skid_opc     <= '0;
            skid_exccode <= '0;
        end else begin
            if (main_from_in) begin
                main_pc      <= in_pc;
                main_instr   <= in_instr;
                main_opc     <= in_opc;
                main_exccode <= in_exccode;
                main_is_nop  <= 1'b0;
            end else if (main_from_skid) begin
                main_pc      <= skid_pc;
                main_instr   <= skid_instr;
                main_opc     <= skid_opc;
                main_exccode <= skid_exccode;
                main_is_nop  <= 1'b0;
            end
            if (skid_from_in) begin
                skid_pc      <= in_pc;
                skid_instr   <= in_instr;
                skid_opc     <= in_opc;
                skid_exccode <= in_exccode;
            end
        end
    end

    // Redirects are counted even when a concurrent flush wins the payload update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           bubble_cnt <= '0;
        else if (redirect) bubble_cnt <= sat_inc(bubble_cnt);
    end

    assign out_pc      = main_pc;
    assign out_instr   = main_instr;
    assign out_opc     = main_opc;
    assign out_exccode = main_exccode;
    assign out_is_nop  = main_is_nop;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; a second instance with a
// 2-bit bubble counter exercises saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, rst2;
    logic        in_valid, flush, redirect, out_ready;
    logic [31:0] in_pc, in_instr, in_opc;
    logic [4:0]  in_exccode;

    logic        in_ready, out_valid, out_is_nop;
    logic [31:0] out_pc, out_instr, out_opc;
    logic [4:0]  out_exccode;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    logic        in_ready2, out_valid2, out_is_nop2;
    logic [31:0] out_pc2, out_instr2, out_opc2;
    logic [4:0]  out_exccode2;
    logic [1:0]  occupancy2;
    logic [1:0]  bubble_cnt2;

    int errors = 0;
    int checks = 0;
    int exp_bub = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_opc(in_opc), .in_exccode(in_exccode),
        .flush(flush), .redirect(redirect), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_opc(out_opc), .out_exccode(out_exccode),
        .out_is_nop(out_is_nop), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_pc(in_pc), .in_instr(in_instr), .in_opc(in_opc), .in_exccode(in_exccode),
        .flush(flush), .redirect(redirect), .out_valid(out_valid2), .out_ready(out_ready),
        .out_pc(out_pc2), .out_instr(out_instr2), .out_opc(out_opc2), .out_exccode(out_exccode2),
        .out_is_nop(out_is_nop2), .occupancy(occupancy2), .bubble_cnt(bubble_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid   = v;
        in_pc      = pc;
        in_instr   = pc + 32'h1000;
        in_opc     = 32'h0;
        in_exccode = 5'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        flush = 0; redirect = 0; out_ready = 0;
        drive(1'b0, 32'h0);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); end
        checks++; if ({out_pc, out_instr, out_opc, out_exccode, out_is_nop} !== '0) begin
            errors++; $display("FAIL reset_payload: got pc=%h instr=%h opc=%h exc=%h nop=%0b want all 0",
                               out_pc, out_instr, out_opc, out_exccode, out_is_nop); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i]);
            tick();
            checks++; if (out_pc !== pcs[i] || out_valid !== 1'b1 || out_instr !== pcs[i] + 32'h1000) begin
                errors++; $display("FAIL stream_out_%0d: got pc=%h instr=%h v=%0b want pc=%h instr=%h v=1",
                                   i, out_pc, out_instr, out_valid, pcs[i], pcs[i] + 32'h1000); end
            checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_occ_%0d: got occ=%0d rdy=%0b want occ=1 rdy=1", i, occupancy, in_ready); end
        end
        drive(1'b0, 32'h0);
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL stream_drain: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 32'h10);
        tick();
        checks++; if (occupancy !== 2'd1 || out_pc !== 32'h10 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_first: got occ=%0d pc=%h rdy=%0b want occ=1 pc=10 rdy=1", occupancy, out_pc, in_ready); end
        drive(1'b1, 32'h14);
        tick();
        checks++; if (occupancy !== 2'd2 || out_pc !== 32'h10 || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_full: got occ=%0d pc=%h rdy=%0b want occ=2 pc=10 rdy=0", occupancy, out_pc, in_ready); end
        drive(1'b1, 32'h18);
        tick();
        checks++; if (occupancy !== 2'd2 || out_pc !== 32'h10 || out_instr !== 32'h1010) begin
            errors++; $display("FAIL stall_hold: got occ=%0d pc=%h instr=%h want occ=2 pc=10 instr=1010", occupancy, out_pc, out_instr); end
        drive(1'b0, 32'h0);
        out_ready = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd1 || out_pc !== 32'h14 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_drain1: got occ=%0d pc=%h rdy=%0b want occ=1 pc=14 rdy=1", occupancy, out_pc, in_ready); end
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain2: got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        drive(1'b1, 32'h20); tick();
        drive(1'b1, 32'h24); tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL redir_prefill: got occ=%0d want 2", occupancy); end
        drive(1'b1, 32'h40);
        redirect = 1'b1;
        tick();
        exp_bub++;
        redirect = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (out_instr !== 32'h20080000 || out_pc !== 32'h40 || out_is_nop !== 1'b1) begin
            errors++; $display("FAIL redir_bubble: got instr=%h pc=%h nop=%0b want instr=20080000 pc=40 nop=1", out_instr, out_pc, out_is_nop); end
        checks++; if (occupancy !== 2'd1 || out_opc !== 32'h0 || out_exccode !== 5'h0) begin
            errors++; $display("FAIL redir_state: got occ=%0d opc=%h exc=%h want occ=1 opc=0 exc=0", occupancy, out_opc, out_exccode); end
        checks++; if (bubble_cnt !== 16'(exp_bub)) begin
            errors++; $display("FAIL redir_count: got %0d want %0d", bubble_cnt, exp_bub); end
        out_ready = 1'b1;
        tick();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL redir_skid_cleared: got occ=%0d v=%0b want occ=0 v=0", occupancy, out_valid); end
    endtask

    task automatic test_flush_redirect();
        out_ready = 1'b0;
        drive(1'b1, 32'h30); tick();
        drive(1'b1, 32'h34);
        flush = 1'b1; redirect = 1'b1;
        tick();
        exp_bub++;
        flush = 1'b0; redirect = 1'b0;
        drive(1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL flush_redir_state: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        checks++; if (bubble_cnt !== 16'(exp_bub)) begin
            errors++; $display("FAIL flush_redir_count: got %0d want %0d", bubble_cnt, exp_bub); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_is_nop !== 1'b0) begin
            errors++; $display("FAIL flush_no_bubble: got v=%0b nop=%0b want v=0 nop=0", out_valid, out_is_nop); end
    endtask

    task automatic test_exception();
        out_ready = 1'b1;
        drive(1'b1, 32'h50);
        in_opc = 32'h80; in_exccode = 5'h0C;
        tick();
        drive(1'b0, 32'h0);
        checks++; if (out_opc !== 32'h80 || out_exccode !== 5'h0C || out_pc !== 32'h50) begin
            errors++; $display("FAIL exc_pass: got opc=%h exc=%h pc=%h want opc=80 exc=0c pc=50", out_opc, out_exccode, out_pc); end
        checks++; if (out_is_nop !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL exc_nop: got nop=%0b v=%0b want nop=0 v=1", out_is_nop, out_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h70); tick();
        drive(1'b1, 32'h74); tick();
        drive(1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        exp_bub = 0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL async_rst_state: got occ=%0d v=%0b rdy=%0b want 0 0 1", occupancy, out_valid, in_ready); end
        checks++; if (bubble_cnt !== 16'd0 || out_pc !== 32'h0) begin
            errors++; $display("FAIL async_rst_clear: got cnt=%0d pc=%h want 0 0", bubble_cnt, out_pc); end
        #1 rst = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 32'h60);
        tick();
        drive(1'b0, 32'h0);
        checks++; if (out_pc !== 32'h60 || occupancy !== 2'd1) begin
            errors++; $display("FAIL async_rst_first: got pc=%h occ=%0d want pc=60 occ=1", out_pc, occupancy); end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp2 [5];
        exp2[0] = 2'd1; exp2[1] = 2'd2; exp2[2] = 2'd3; exp2[3] = 2'd3; exp2[4] = 2'd3;
        rst2 = 1'b0;
        tick();
        redirect = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bubble_cnt2 !== exp2[i]) begin
                errors++; $display("FAIL sat_count_%0d: got %0d want %0d", i, bubble_cnt2, exp2[i]); end
        end
        redirect = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_redirect();
        test_flush_redirect();
        test_exception();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, width of PC and OPC fields.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter EXC_W, default 5, exception-code width.
REQ-004 SHALL have parameter NOP_INSTR, default 32'h20080000, bubble instruction pattern.
REQ-005 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports in_valid in 1 / in_ready out 1: upstream handshake.
REQ-009 SHALL have ports in_pc in PC_W, in_instr in INSTR_W, in_opc in PC_W, in_exccode in EXC_W: upstream payload.
REQ-010 SHALL have port flush  in  1  kill all held entries.
REQ-011 SHALL have port redirect  in  1  jump/branch/eret taken; inject bubble.
REQ-012 SHALL have ports out_valid out 1 / out_ready in 1: downstream handshake.
REQ-013 SHALL have ports out_pc out PC_W, out_instr out INSTR_W, out_opc out PC_W, out_exccode out EXC_W, out_is_nop out 1: downstream payload.
REQ-014 SHALL have port occupancy  out  2  entries held (0..2).
REQ-015 SHALL have port bubble_cnt  out  CNT_W  bubbles injected since reset.

Function
REQ-016 SHALL hold two entries: MAIN (drives out_*) and SKID; state = EMPTY (0), ONE (MAIN only), FULL (MAIN+SKID).
REQ-017 SHALL drive in_ready = 1 iff SKID empty, from registered state only (no combinational path from out_ready).
REQ-018 SHALL define accept = in_valid & in_ready, drain = out_valid & out_ready, evaluated per rising edge.
REQ-019 SHALL, in normal mode: EMPTY+accept -> ONE; ONE+accept+drain -> ONE (MAIN <= input); ONE+accept+!drain -> FULL (SKID <= input); ONE+!accept+drain -> EMPTY; FULL+drain -> ONE (MAIN <= SKID); otherwise hold.
REQ-020 SHALL present out_valid = 1 iff MAIN occupied; out_* SHALL be stable while out_valid & !out_ready.
REQ-021 SHALL give latency of exactly one cycle: beat accepted at edge N is on out_* after edge N when MAIN was empty or draining.
REQ-022 SHALL, on redirect (no flush), at next edge: MAIN <= {pc=in_pc, instr=NOP_INSTR, opc=0, exccode=0, is_nop=1}, SKID cleared, state ONE; the concurrent input beat is consumed and discarded; any MAIN/SKID contents are discarded regardless of out_ready.
REQ-023 SHALL, on flush, at next edge: MAIN and SKID cleared, state EMPTY, concurrent input discarded.
REQ-024 SHALL give priority rst > flush > redirect > normal.
REQ-025 SHALL set out_is_nop = 0 for every normally accepted beat; opc and exccode pass unchanged.
REQ-026 SHALL increment bubble_cnt by 1 per redirect edge (not suppressed by flush) and saturate at all-ones.
REQ-027 SHALL drive occupancy = 0/1/2 for EMPTY/ONE/FULL.

Reset
REQ-028 SHALL, while rst = 1 (asynchronous), force state EMPTY, out_valid 0, in_ready 1, out_pc/out_instr/out_opc/out_exccode 0, out_is_nop 0, occupancy 0, bubble_cnt 0.
REQ-029 SHALL, on rst mid-transfer, discard all held beats; first post-reset accept behaves as from EMPTY.

Verification
REQ-030 SHALL cover streaming: out_ready=1, beats pc=0x0,0x4,0x8 back-to-back -> same pcs on out_pc one cycle later, occupancy never 2, in_ready constantly 1.
REQ-031 SHALL cover stall: out_ready=0, accept pc=0x10 then 0x14 -> occupancy 2, in_ready 0, out_pc holds 0x10; out_ready=1 -> 0x10 then 0x14 emitted, in_ready 1 after first drain.
REQ-032 SHALL cover redirect: FULL state, redirect=1 with in_pc=0x40 -> next cycle out_instr=0x20080000, out_pc=0x40, out_is_nop=1, occupancy 1, bubble_cnt +1.
REQ-033 SHALL cover flush+redirect same edge: -> out_valid 0, occupancy 0, bubble_cnt +1, no bubble emitted.
REQ-034 SHALL cover exception pass-through: in_exccode=5'h0C, in_opc=0x80 -> identical on outputs, out_is_nop 0.
REQ-035 SHALL cover async reset mid-stall and counter saturation (CNT_W=2, 5 redirects -> bubble_cnt=3).
